// File: rtl/regfile_wb.sv
// Write-back register file: 2**AW x DW array, r0 hardwired to zero.
// Build with REGFILE_BYPASS_EN to forward the same-cycle write to reads.
module regfile_wb #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst_,
   input  logic [AW-1:0] wb_wd,
   input  logic          wb_wreg,
   input  logic [DW-1:0] wb_wdata,
   input  logic          wb_stall,
   input  logic          re0,
   input  logic [AW-1:0] raddr0,
   output logic [DW-1:0] rdata0,
   input  logic          re1,
   input  logic [AW-1:0] raddr1,
   output logic [DW-1:0] rdata1,
   output logic          wr_commit
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] regs_q [DEPTH];
   logic          wr_commit_q;
   logic          wr_commit_d;
   logic          wr_live;

   // A write is "live" when it would update the array this edge,
   // ignoring reset; reset is folded into the commit separately.
   assign wr_live     = wb_wreg && !wb_stall && (wb_wd != '0);
   assign wr_commit_d = rst_ && wr_live;

   always_ff @(posedge clk) begin
      if (!rst_) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         wr_commit_q <= 1'b0;
      end else begin
         if (wr_commit_d) begin
            regs_q[wb_wd] <= wb_wdata;
         end
         wr_commit_q <= wr_commit_d;
      end
   end

   assign wr_commit = wr_commit_q;

   function automatic logic [DW-1:0] rd_port(
      input logic          rst_n,
      input logic          re,
      input logic [AW-1:0] ra,
      input logic          live,
      input logic [AW-1:0] wd,
      input logic [DW-1:0] wdata,
      input logic [DW-1:0] arr
   );
      logic [DW-1:0] res;
      res = '0;
      if (!rst_n || !re || (ra == '0)) begin
         res = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (live && (ra == wd)) begin
         res = wdata;
`endif
      end else begin
         res = arr;
      end
`ifndef REGFILE_BYPASS_EN
      if (live && (wd == '0) && (wdata == '0)) begin
         res = res;
      end
`endif
      return res;
   endfunction

   always_comb begin
      rdata0 = '0;
      rdata0 = rd_port(rst_, re0, raddr0, wr_live, wb_wd,
                       wb_wdata, regs_q[raddr0]);
   end

   always_comb begin
      rdata1 = '0;
      rdata1 = rd_port(rst_, re1, raddr1, wr_live, wb_wd,
                       wb_wdata, regs_q[raddr1]);
   end

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed vector table, then random traffic
// checked against an array model of the register file.
module tb_regfile_wb;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst_;
   logic [4:0]  wb_wd;
   logic        wb_wreg;
   logic [31:0] wb_wdata;
   logic        wb_stall;
   logic        re0;
   logic [4:0]  raddr0;
   logic [31:0] rdata0;
   logic        re1;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic        wr_commit;

   int checks = 0;
   int failures = 0;

   regfile_wb #(.DW(32), .AW(5)) dut (
      .clk(clk), .rst_(rst_),
      .wb_wd(wb_wd), .wb_wreg(wb_wreg),
      .wb_wdata(wb_wdata), .wb_stall(wb_stall),
      .re0(re0), .raddr0(raddr0), .rdata0(rdata0),
      .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
      .wr_commit(wr_commit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        wreg;
      logic [4:0]  wd;
      logic [31:0] wdata;
      logic        stall;
      logic        re0;
      logic [4:0]  ra0;
      logic        re1;
      logic [4:0]  ra1;
      logic [31:0] e0;
      logic [31:0] e1;
      logic        ewc;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(
      input logic rst, input logic wreg, input logic [4:0] wd,
      input logic [31:0] wdata, input logic stall,
      input logic r0e, input logic [4:0] a0,
      input logic r1e, input logic [4:0] a1,
      input logic [31:0] e0, input logic [31:0] e1,
      input logic ewc);
      vec_t v;
      v.rst = rst; v.wreg = wreg; v.wd = wd; v.wdata = wdata;
      v.stall = stall; v.re0 = r0e; v.ra0 = a0;
      v.re1 = r1e; v.ra1 = a1;
      v.e0 = e0; v.e1 = e1; v.ewc = ewc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic wreg,
                        input logic [4:0] wd, input logic [31:0] wdata,
                        input logic stall, input logic r0e,
                        input logic [4:0] a0, input logic r1e,
                        input logic [4:0] a1);
      rst_ = rst; wb_wreg = wreg; wb_wd = wd; wb_wdata = wdata;
      wb_stall = stall; re0 = r0e; raddr0 = a0;
      re1 = r1e; raddr1 = a1;
   endtask

   // Reference model state
   logic [31:0] m [32];
   logic        m_wc;

   function automatic logic [31:0] m_rd(input logic r0e,
                                        input logic [4:0] a);
      if (!rst_ || !r0e || a == 5'd0) return 32'h0;
      if (BYP && wb_wreg && !wb_stall && a == wb_wd) return wb_wdata;
      return m[a];
   endfunction

   logic [31:0] old9, new9;

   initial begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
      @(posedge clk); #1;

      old9 = 32'hA;
      new9 = 32'hB;
      tv.push_back(mk(0,1,3,32'hAAAAAAAA,0, 1,3, 1,31, 0,0,0));
      tv.push_back(mk(0,1,3,32'hAAAAAAAA,0, 1,3, 1,31, 0,0,0));
      tv.push_back(mk(1,0,0,32'h0,0, 1,3, 1,31, 0,0,0));
      tv.push_back(mk(1,1,5,32'hDEADBEEF,0, 1,5, 1,5,
                      BYP ? 32'hDEADBEEF : 32'h0,
                      BYP ? 32'hDEADBEEF : 32'h0, 0));
      tv.push_back(mk(1,0,0,32'h0,0, 1,5, 1,5,
                      32'hDEADBEEF,32'hDEADBEEF,1));
      tv.push_back(mk(1,1,0,32'hFFFFFFFF,0, 1,0, 1,5,
                      0,32'hDEADBEEF,0));
      tv.push_back(mk(1,0,0,32'h0,0, 1,0, 1,0, 0,0,0));
      tv.push_back(mk(1,1,7,32'h11111111,0, 1,5, 0,7,
                      32'hDEADBEEF,0,0));
      tv.push_back(mk(1,1,7,32'h22222222,1, 1,7, 1,7,
                      32'h11111111,32'h11111111,1));
      tv.push_back(mk(1,1,7,32'h22222222,1, 1,7, 1,7,
                      32'h11111111,32'h11111111,0));
      tv.push_back(mk(1,1,7,32'h22222222,0, 1,5, 1,0,
                      32'hDEADBEEF,0,0));
      tv.push_back(mk(1,0,0,32'h0,0, 1,7, 1,7,
                      32'h22222222,32'h22222222,1));
      tv.push_back(mk(1,1,9,old9,0, 0,9, 0,9, 0,0,0));
      tv.push_back(mk(1,1,9,new9,0, 1,9, 0,9,
                      BYP ? new9 : old9, 0, 1));
      tv.push_back(mk(1,0,0,32'h0,0, 1,9, 1,9, new9,new9,1));
      tv.push_back(mk(1,1,12,32'h1234,0, 1,9, 1,5,
                      new9,32'hDEADBEEF,0));
      tv.push_back(mk(0,1,12,32'h5678,0, 1,12, 1,12, 0,0,1));
      tv.push_back(mk(1,0,0,32'h0,0, 1,12, 1,5, 0,0,0));

      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].rst, tv[i].wreg, tv[i].wd, tv[i].wdata,
               tv[i].stall, tv[i].re0, tv[i].ra0,
               tv[i].re1, tv[i].ra1);
         @(negedge clk);
         chk($sformatf("vec%0d rdata0", i), rdata0, tv[i].e0);
         chk($sformatf("vec%0d rdata1", i), rdata1, tv[i].e1);
         chk($sformatf("vec%0d wr_commit", i),
             {31'h0, wr_commit}, {31'h0, tv[i].ewc});
         @(posedge clk); #1;
      end

      // Array was cleared by the last reset in the table.
      for (int i = 0; i < 32; i++) m[i] = 32'h0;
      m_wc = 1'b0;

      for (int n = 0; n < 400; n++) begin
         logic [4:0] a0, a1, wd;
         wd = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                          : 5'($urandom_range(0, 7));
         a0 = ($urandom_range(0, 3) == 0) ? 5'($urandom)
                                          : 5'($urandom_range(0, 7));
         a1 = ($urandom_range(0, 2) == 0) ? a0 : 5'($urandom_range(0, 7));
         drive(($urandom_range(0, 19) != 0),
               ($urandom_range(0, 3) != 0), wd, $urandom,
               ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 5) != 0), a0,
               ($urandom_range(0, 5) != 0), a1);
         @(negedge clk);
         chk($sformatf("rnd%0d rdata0", n), rdata0, m_rd(re0, raddr0));
         chk($sformatf("rnd%0d rdata1", n), rdata1, m_rd(re1, raddr1));
         chk($sformatf("rnd%0d wr_commit", n),
             {31'h0, wr_commit}, {31'h0, m_wc});
         @(posedge clk);
         if (!rst_) begin
            for (int i = 0; i < 32; i++) m[i] = 32'h0;
            m_wc = 1'b0;
         end else begin
            m_wc = wb_wreg && !wb_stall && wb_wd != 5'd0;
            if (m_wc) m[wb_wd] = wb_wdata;
         end
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
